// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one registered 32-bit ALU between two requesters.
// Optional statistics counters are enabled by defining ALU_ARB_STATS_EN.
module alu_share_arbiter #(
    parameter int EXEC_CYCLES = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [31:0]      req_a0,
    input  logic [31:0]      req_a1,
    input  logic [31:0]      req_b0,
    input  logic [31:0]      req_b1,
    input  logic [2:0]       req_op0,
    input  logic [2:0]       req_op1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [31:0]      rsp_f,
    output logic             rsp_zf,
    output logic             rsp_of,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_op,
    input  logic [31:0]      alu_f,
    input  logic             alu_zf,
    input  logic             alu_of
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1,
    output logic [CNT_W-1:0] of_cnt
`endif
);

    localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(EXEC_CYCLES - 1);

    if (EXEC_CYCLES < 1 || CNT_W < 1) begin : g_param_check
        $error("alu_share_arbiter: EXEC_CYCLES and CNT_W must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          last_gnt_q, last_gnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   alu_a_q, alu_a_d;
    logic [31:0]   alu_b_q, alu_b_d;
    logic [2:0]    alu_op_q, alu_op_d;
    logic [31:0]   rsp_f_q, rsp_f_d;
    logic          rsp_zf_q, rsp_zf_d;
    logic          rsp_of_q, rsp_of_d;
    logic          sel;

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] gnt_cnt0_q, gnt_cnt0_d;
    logic [CNT_W-1:0] gnt_cnt1_q, gnt_cnt1_d;
    logic [CNT_W-1:0] of_cnt_q, of_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction
`endif

    // A tie goes to whoever did not win last; a lone requester always wins.
    always_comb begin
        if (req_valid == 2'b11) begin
            sel = ~last_gnt_q;
        end else begin
            sel = req_valid[1];
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        cnt_d      = cnt_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        rsp_f_d    = rsp_f_q;
        rsp_zf_d   = rsp_zf_q;
        rsp_of_d   = rsp_of_q;
        req_ready  = 2'b00;
        rsp_valid  = 2'b00;
`ifdef ALU_ARB_STATS_EN
        gnt_cnt0_d = gnt_cnt0_q;
        gnt_cnt1_d = gnt_cnt1_q;
        of_cnt_d   = of_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                // Ready is masked during reset so nothing can transfer.
                if ((|req_valid) && !rst) begin
                    req_ready[sel] = 1'b1;
                    alu_a_d  = sel ? req_a1  : req_a0;
                    alu_b_d  = sel ? req_b1  : req_b0;
                    alu_op_d = sel ? req_op1 : req_op0;
                    gnt_d    = sel;
                    cnt_d    = '0;
                    state_d  = EXEC;
`ifdef ALU_ARB_STATS_EN
                    if (sel) gnt_cnt1_d = sat_inc(gnt_cnt1_q);
                    else     gnt_cnt0_d = sat_inc(gnt_cnt0_q);
`endif
                end
            end
            EXEC: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    rsp_f_d  = alu_f;
                    rsp_zf_d = alu_zf;
                    rsp_of_d = alu_of;
                    state_d  = RESP;
`ifdef ALU_ARB_STATS_EN
                    if (alu_of) of_cnt_d = sat_inc(of_cnt_q);
`endif
                end
            end
            RESP: begin
                rsp_valid[gnt_q] = 1'b1;
                if (rsp_ready[gnt_q]) begin
                    last_gnt_d = gnt_q;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            cnt_q      <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            rsp_f_q    <= '0;
            rsp_zf_q   <= 1'b0;
            rsp_of_q   <= 1'b0;
`ifdef ALU_ARB_STATS_EN
            gnt_cnt0_q <= '0;
            gnt_cnt1_q <= '0;
            of_cnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            rsp_f_q    <= rsp_f_d;
            rsp_zf_q   <= rsp_zf_d;
            rsp_of_q   <= rsp_of_d;
`ifdef ALU_ARB_STATS_EN
            gnt_cnt0_q <= gnt_cnt0_d;
            gnt_cnt1_q <= gnt_cnt1_d;
            of_cnt_q   <= of_cnt_d;
`endif
        end
    end

    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign alu_op = alu_op_q;
    assign rsp_f  = rsp_f_q;
    assign rsp_zf = rsp_zf_q;
    assign rsp_of = rsp_of_q;
`ifdef ALU_ARB_STATS_EN
    assign gnt_cnt0 = gnt_cnt0_q;
    assign gnt_cnt1 = gnt_cnt1_q;
    assign of_cnt   = of_cnt_q;
`endif

endmodule
